// File: rtl/rv_clint_pkg.sv
// Shared address map and byte-merge helper for the rv_io_clint timer/IPI block.
package rv_clint_pkg;

  localparam logic [15:0] CLINT_MSIP     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP = 16'h4000;
  localparam logic [15:0] CLINT_PRESCALE = 16'hBFF0;
  localparam logic [15:0] CLINT_MTIME    = 16'hBFF8;

  // A 32-bit access carries its byte enables in mask[3:0]; hi steers them onto bytes 7..4.
  function automatic logic [63:0] merge64(input logic [63:0] old, input logic [63:0] wdata,
                                          input logic [7:0] mask, input logic hi);
    logic [7:0] m;
    merge64 = old;
    m = hi ? {mask[3:0], 4'b0000} : mask;
    for (int b = 0; b < 8; b++)
      if (m[b]) merge64[8*b +: 8] = wdata[8*b +: 8];
  endfunction

endpackage

// File: rtl/rv_clint_prescaler.sv
// Programmable mtime prescaler: divisor/enable registers and a reloading down-counter.
module rv_clint_prescaler
  import rv_clint_pkg::*;
#(
  parameter int PRESCALE_W   = 12,
  parameter int PRESCALE_RST = 31
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic [PRESCALE_W-1:0] wr_div,
  input  logic                  wr_enable,
  output logic [PRESCALE_W-1:0] div,
  output logic                  enable,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div    <= PRESCALE_W'(PRESCALE_RST);
      enable <= 1'b1;
      cnt    <= PRESCALE_W'(PRESCALE_RST);
    end else if (wr) begin
      div    <= wr_div;
      enable <= wr_enable;
      cnt    <= wr_div;
    end else if (enable) begin
      cnt <= (cnt == '0) ? div : cnt - PRESCALE_W'(1);
    end
  end

  assign tick = enable & (cnt == '0);

endmodule

// File: rtl/rv_io_clint.sv
// CLINT on the IO bus: per-hart msip/mtimecmp, shared prescaled 64-bit mtime, MTIP/MSIP lines.
module rv_io_clint
  import rv_clint_pkg::*;
#(
  parameter int RV           = 64,
  parameter int NCPU         = 1,
  parameter int PRESCALE_W   = 12,
  parameter int PRESCALE_RST = 31
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            addr_req,
  output logic            addr_ack,
  input  logic            sel,
  input  logic [15:0]     addr,
  input  logic            read,
  input  logic [7:0]      mask,
  input  logic [RV-1:0]   wdata,
  output logic            data_req,
  input  logic            data_ack,
  output logic [RV-1:0]   rdata,
  output logic [63:0]     timer,
  output logic [NCPU-1:0] timer_interrupt,
  output logic [NCPU-1:0] ip_interrupt
);

  logic                  rd_acc, wr_acc, hi, unused;
  logic [63:0]           wdata64, rd64, r_timer, pre_cur, pre_new;
  logic [7:0]            mask_n, mask_eff;
  logic                  is_msip, is_cmp, is_pre, is_time;
  logic [12:0]           cmp_idx;
  logic [PRESCALE_W-1:0] div;
  logic                  enable, tick;
  logic [63:0]           r_cmp [NCPU];
  logic [NCPU-1:0]       r_msip, r_timer_int;

  assign addr_ack = addr_req & sel & ~(data_req & ~data_ack);
  assign rd_acc   = addr_ack & read;
  assign wr_acc   = addr_ack & ~read;

  // Both bus widths are normalised to a 64-bit word; RV=32 picks its half with addr[2].
  assign hi       = (RV == 32) && addr[2];
  assign wdata64  = (RV == 32) ? {2{wdata[31:0]}} : 64'(wdata);
  assign mask_n   = (RV == 32) ? {4'b0000, mask[3:0]} : mask;
  assign mask_eff = hi ? {mask[3:0], 4'b0000} : mask_n;

  assign is_msip = addr[15:14] == CLINT_MSIP[15:14];
  assign is_pre  = addr[15:3] == CLINT_PRESCALE[15:3];
  assign is_time = addr[15:3] == CLINT_MTIME[15:3];
  assign is_cmp  = (addr[15:14] == 2'b01 || addr[15:14] == 2'b10) &&
                   addr[15:4] != CLINT_PRESCALE[15:4];
  assign cmp_idx = addr[15:3] - CLINT_MTIMECMP[15:3];

  assign pre_cur = 64'(div) | (64'(enable) << 31);
  assign pre_new = merge64(pre_cur, wdata64, mask_n, hi);
  assign unused  = ^{addr[1:0], pre_new};

  rv_clint_prescaler #(
    .PRESCALE_W  (PRESCALE_W),
    .PRESCALE_RST(PRESCALE_RST)
  ) u_prescaler (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr       (wr_acc & is_pre),
    .wr_div   (pre_new[PRESCALE_W-1:0]),
    .wr_enable(pre_new[31]),
    .div      (div),
    .enable   (enable),
    .tick     (tick)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    rd64 = '0;
    if (is_msip) begin
      for (int h = 0; h < NCPU; h++)
        if (addr[13:3] == 11'(h >> 1)) begin
          if (h % 2 == 1) rd64[32] = r_msip[h];
          else            rd64[0]  = r_msip[h];
        end
    end else if (is_cmp) begin
      for (int h = 0; h < NCPU; h++)
        if (cmp_idx == 13'(h)) rd64 = r_cmp[h];
    end else if (is_pre) begin
      rd64 = pre_cur;
    end else if (is_time) begin
      rd64 = r_timer;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_req <= 1'b0;
      rdata    <= '0;
    end else if (rd_acc) begin
      data_req <= 1'b1;
      rdata    <= RV'(hi ? (rd64 >> 32) : rd64);
    end else if (data_ack) begin
      data_req <= 1'b0;
    end
  end

  // Unwritten bytes of a same-cycle write still see the tick increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               r_timer <= '0;
    else if (wr_acc && is_time) r_timer <= merge64(r_timer + 64'(tick), wdata64, mask_n, hi);
    else                        r_timer <= r_timer + 64'(tick);
  end

  for (genvar h = 0; h < NCPU; h++) begin : g_hart
    localparam int B  = (h % 2) * 32;
    localparam int MB = (h % 2) * 4;
    logic        msip_q, mtip_q;
    logic [63:0] cmp_q;

    // NOTE: mtimecmp resets to all ones so no hart sees MTIP straight out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        msip_q <= 1'b0;
        cmp_q  <= '1;
        mtip_q <= 1'b0;
      end else begin
        if (wr_acc && is_msip && addr[13:3] == 11'(h >> 1) && mask_eff[MB])
          msip_q <= wdata64[B];
        if (wr_acc && is_cmp && cmp_idx == 13'(h))
          cmp_q <= merge64(cmp_q, wdata64, mask_n, hi);
        mtip_q <= r_timer >= cmp_q;
      end
    end

    assign r_msip[h]      = msip_q;
    assign r_cmp[h]       = cmp_q;
    assign r_timer_int[h] = mtip_q;
  end

  assign timer           = r_timer;
  assign timer_interrupt = r_timer_int;
  assign ip_interrupt    = r_msip;

endmodule

// File: tb/tb_rv_io_clint.sv
// Bench for rv_io_clint: an RV=64/NCPU=3 and an RV=32/NCPU=2 instance share one request bus.
module tb_rv_io_clint;

  logic        clk, reset_n, addr_req, sel, tgt, read, data_ack;
  logic [15:0] addr;
  logic [7:0]  mask;
  logic [63:0] wdata;
  logic        ack64, ack32, dreq64, dreq32;
  logic [63:0] rdata64, timer64, timer32;
  logic [31:0] rdata32;
  logic [2:0]  mtip64, msip64;
  logic [1:0]  mtip32, msip32;

  int checks   = 0;
  int failures = 0;

  rv_io_clint #(.RV(64), .NCPU(3), .PRESCALE_W(12), .PRESCALE_RST(31)) u64 (
    .clk(clk), .reset_n(reset_n), .addr_req(addr_req), .addr_ack(ack64), .sel(sel & ~tgt),
    .addr(addr), .read(read), .mask(mask), .wdata(wdata), .data_req(dreq64),
    .data_ack(data_ack), .rdata(rdata64), .timer(timer64),
    .timer_interrupt(mtip64), .ip_interrupt(msip64));

  rv_io_clint #(.RV(32), .NCPU(2), .PRESCALE_W(12), .PRESCALE_RST(31)) u32 (
    .clk(clk), .reset_n(reset_n), .addr_req(addr_req), .addr_ack(ack32), .sel(sel & tgt),
    .addr(addr), .read(read), .mask(mask), .wdata(wdata[31:0]), .data_req(dreq32),
    .data_ack(data_ack), .rdata(rdata32), .timer(timer32),
    .timer_interrupt(mtip32), .ip_interrupt(msip32));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic cur_ack();
    return tgt ? ack32 : ack64;
  endfunction

  function automatic logic cur_dreq();
    return tgt ? dreq32 : dreq64;
  endfunction

  function automatic logic [63:0] cur_rdata();
    return tgt ? 64'(rdata32) : rdata64;
  endfunction

  // Present one request and return just after the edge that accepts it.
  task automatic issue(input bit t, input bit rd, input logic [15:0] a,
                       input logic [7:0] m, input logic [63:0] d);
    int n = 0;
    @(negedge clk);
    tgt = t; sel = 1'b1; addr_req = 1'b1; read = rd; addr = a; mask = m; wdata = d;
    #1;
    while (!cur_ack() && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n == 20) check("ack_wait", 64'(cur_ack()), 64'd1);
    @(posedge clk); #1;
    addr_req = 1'b0; sel = 1'b0;
  endtask

  task automatic bus_read(input bit t, input logic [15:0] a, output logic [63:0] d);
    int n = 0;
    issue(t, 1'b1, a, 8'hFF, 64'd0);
    while (!cur_dreq() && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n == 20) check("dreq_wait", 64'(cur_dreq()), 64'd1);
    d = cur_rdata();
    data_ack = 1'b1;
    @(posedge clk); #1;
    data_ack = 1'b0;
  endtask

  // Reference state for the randomized phase (NCPU=3, mtime frozen).
  logic [63:0] m_mtime;
  logic [63:0] m_cmp [3];
  logic        m_msip [3];

  function automatic logic [63:0] byte_bits(input logic [7:0] m);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = {8{m[b]}};
    return r;
  endfunction

  function automatic logic [63:0] mdl_read(input logic [15:0] a);
    int idx;
    if (a == 16'h0000) return (64'(m_msip[1]) << 32) | 64'(m_msip[0]);
    if (a == 16'h0008) return 64'(m_msip[2]);
    if (a >= 16'h4000 && a < 16'h4018) begin
      idx = int'(a - 16'h4000) / 8;
      return m_cmp[idx];
    end
    if (a == 16'hBFF8) return m_mtime;
    return 64'd0;
  endfunction

  task automatic mdl_write(input logic [15:0] a, input logic [7:0] m, input logic [63:0] d);
    logic [63:0] bm;
    int idx;
    bm = byte_bits(m);
    if (a == 16'h0000) begin
      if (m[0]) m_msip[0] = d[0];
      if (m[4]) m_msip[1] = d[32];
    end else if (a == 16'h0008) begin
      if (m[0]) m_msip[2] = d[0];
    end else if (a >= 16'h4000 && a < 16'h4018) begin
      idx = int'(a - 16'h4000) / 8;
      m_cmp[idx] = (m_cmp[idx] & ~bm) | (d & bm);
    end else if (a == 16'hBFF8) begin
      m_mtime = (m_mtime & ~bm) | (d & bm);
    end
  endtask

  typedef struct {
    logic        rd;
    logic [15:0] a;
    logic [7:0]  m;
    logic [63:0] d;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [63:0] got, d;
    logic [15:0] a;
    logic [7:0]  m;
    logic [2:0]  exp_mtip, exp_msip;
    bit          rd;
    int          kind, h;

    tbl[0]  = '{1'b1, 16'h4000, 8'hFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[1]  = '{1'b1, 16'h4010, 8'hFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[2]  = '{1'b1, 16'h4018, 8'hFF, 64'd0, 64'd0};
    tbl[3]  = '{1'b1, 16'hBFF0, 8'hFF, 64'd0, 64'h0000_0000_8000_001F};
    tbl[4]  = '{1'b1, 16'h0000, 8'hFF, 64'd0, 64'd0};
    tbl[5]  = '{1'b0, 16'h0000, 8'h11, 64'h0000_0001_0000_0001, 64'd0};
    tbl[6]  = '{1'b1, 16'h0000, 8'hFF, 64'd0, 64'h0000_0001_0000_0001};
    tbl[7]  = '{1'b0, 16'h0008, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
    tbl[8]  = '{1'b1, 16'h0008, 8'hFF, 64'd0, 64'd1};
    tbl[9]  = '{1'b0, 16'h4008, 8'h0F, 64'h1234_5678_9ABC_DEF0, 64'd0};
    tbl[10] = '{1'b1, 16'h4008, 8'hFF, 64'd0, 64'hFFFF_FFFF_9ABC_DEF0};
    tbl[11] = '{1'b0, 16'hC000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
    tbl[12] = '{1'b1, 16'hC000, 8'hFF, 64'd0, 64'd0};
    tbl[13] = '{1'b0, 16'h0000, 8'h01, 64'd0, 64'd0};
    tbl[14] = '{1'b1, 16'h0000, 8'hFF, 64'd0, 64'h0000_0001_0000_0000};

    clk = 1'b0; reset_n = 1'b0; addr_req = 1'b0; sel = 1'b0; tgt = 1'b0; read = 1'b0;
    data_ack = 1'b0; addr = '0; mask = '0; wdata = '0;

    // Reset state and default divide-by-32 mtime.
    #12;
    check("rst_data_req", 64'(dreq64), 64'd0);
    check("rst_rdata", rdata64, 64'd0);
    check("rst_timer", timer64, 64'd0);
    check("rst_mtip", 64'(mtip64), 64'd0);
    check("rst_msip", 64'(msip64), 64'd0);
    @(negedge clk) reset_n = 1'b1;
    repeat (31) @(negedge clk);
    check("mtime_31clk", timer64, 64'd0);
    @(negedge clk);
    check("mtime_32clk", timer64, 64'd1);
    check("mtime32_32clk", timer32, 64'd1);
    repeat (32) @(negedge clk);
    check("mtime_64clk", timer64, 64'd2);
    check("mtip_idle", 64'(mtip64), 64'd0);

    // Register map vectors on the RV=64 instance.
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].rd) begin
        bus_read(1'b0, tbl[i].a, got);
        check($sformatf("tbl%0d_rd_%h", i, tbl[i].a), got, tbl[i].exp);
      end else begin
        issue(1'b0, 1'b0, tbl[i].a, tbl[i].m, tbl[i].d);
      end
    end
    check("msip_lines", 64'(msip64), 64'b110);

    // MTIP timing with div=0.
    issue(1'b0, 1'b0, 16'hBFF0, 8'h08, 64'd0);
    issue(1'b0, 1'b0, 16'hBFF8, 8'hFF, 64'd0);
    issue(1'b0, 1'b0, 16'h4010, 8'hFF, 64'd5);
    issue(1'b0, 1'b0, 16'hBFF0, 8'h0F, 64'h8000_0000);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      check($sformatf("mtime_k%0d", k), timer64, 64'(k));
      check($sformatf("mtip2_k%0d", k), 64'(mtip64[2]), 64'(k >= 6));
    end
    check("mtip01_low", 64'(mtip64[1:0]), 64'd0);
    issue(1'b0, 1'b0, 16'h4010, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    check("mtip2_hold", 64'(mtip64[2]), 64'd1);
    @(posedge clk); #1;
    check("mtip2_drop", 64'(mtip64[2]), 64'd0);

    // RV=32: half selection and a high-word write colliding with a tick.
    issue(1'b1, 1'b0, 16'hBFF0, 8'h0F, 64'h8000_0000);
    issue(1'b1, 1'b0, 16'hBFF8, 8'h0F, 64'h0000_0100);
    check("r32_mtime_lo", timer32, 64'h0000_0000_0000_0100);
    issue(1'b1, 1'b0, 16'hBFFC, 8'h0F, 64'h0000_DEAD);
    check("r32_mtime_hi_tick", timer32, 64'h0000_DEAD_0000_0101);
    bus_read(1'b1, 16'hBFFC, got);
    check("r32_rd_hi", got, 64'h0000_DEAD);
    bus_read(1'b1, 16'hBFF0, got);
    check("r32_rd_pre", got, 64'h8000_0000);
    bus_read(1'b1, 16'hBFF4, got);
    check("r32_rd_pre_hi", got, 64'd0);
    issue(1'b1, 1'b0, 16'h0004, 8'h0F, 64'd1);
    bus_read(1'b1, 16'h0004, got);
    check("r32_msip1", got, 64'd1);
    bus_read(1'b1, 16'h0000, got);
    check("r32_msip0", got, 64'd0);
    check("r32_msip_lines", 64'(msip32), 64'b10);

    // Read back-pressure, then ack and a new read in the same cycle.
    issue(1'b0, 1'b1, 16'h4010, 8'hFF, 64'd0);
    check("bp_first_dreq", 64'(dreq64), 64'd1);
    @(negedge clk);
    tgt = 1'b0; sel = 1'b1; addr_req = 1'b1; read = 1'b1; addr = 16'h0000; mask = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_ack_%0d", i), 64'(ack64), 64'd0);
      check($sformatf("bp_rdata_%0d", i), rdata64, 64'hFFFF_FFFF_FFFF_FFFF);
      check($sformatf("bp_dreq_%0d", i), 64'(dreq64), 64'd1);
      @(negedge clk);
    end
    data_ack = 1'b1;
    #1;
    check("bp_ack_release", 64'(ack64), 64'd1);
    @(posedge clk); #1;
    addr_req = 1'b0; sel = 1'b0;
    check("b2b_dreq", 64'(dreq64), 64'd1);
    check("b2b_rdata", rdata64, 64'h0000_0001_0000_0000);
    @(posedge clk); #1;
    data_ack = 1'b0;
    check("b2b_drop", 64'(dreq64), 64'd0);

    // mtime wrap, then asynchronous reset while a read is pending.
    issue(1'b0, 1'b0, 16'hBFF8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    check("wrap_pre", timer64, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk); #1;
    check("wrap_zero", timer64, 64'd0);
    issue(1'b0, 1'b1, 16'hBFF0, 8'hFF, 64'd0);
    check("midrd_dreq", 64'(dreq64), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("midrd_async_drop", 64'(dreq64), 64'd0);
    check("midrd_rdata", rdata64, 64'd0);
    check("midrd_msip", 64'(msip64), 64'd0);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_dreq", 64'(dreq64), 64'd0);

    // Randomized register traffic against the reference model, mtime frozen.
    issue(1'b0, 1'b0, 16'hBFF0, 8'hFF, 64'd0);
    issue(1'b0, 1'b0, 16'hBFF8, 8'hFF, 64'd0);
    m_mtime = 64'd0;
    for (int i = 0; i < 3; i++) begin
      m_cmp[i]  = 64'hFFFF_FFFF_FFFF_FFFF;
      m_msip[i] = 1'b0;
    end
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0:       a = 16'h0000;
        1:       a = 16'h0008;
        2, 3:    begin h = $urandom_range(0, 3); a = 16'h4000 + 16'(8 * h); end
        4:       a = 16'hBFF8;
        default: a = 16'hC000 + 16'($urandom_range(0, 2047) * 8);
      endcase
      rd = 1'($urandom_range(0, 1));
      m  = 8'($urandom_range(0, 255));
      d  = {($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'h0, 32'($urandom_range(0, 40))};
      if (rd) begin
        bus_read(1'b0, a, got);
        check($sformatf("rnd%0d_rd_%h", it, a), got, mdl_read(a));
      end else begin
        issue(1'b0, 1'b0, a, m, d);
        mdl_write(a, m, d);
      end
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        exp_mtip[k] = m_mtime >= m_cmp[k];
        exp_msip[k] = m_msip[k];
      end
      check($sformatf("rnd%0d_mtip", it), 64'(mtip64), 64'(exp_mtip));
      check($sformatf("rnd%0d_msip", it), 64'(msip64), 64'(exp_msip));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
